regfile_wb_queue: RTL and testbench

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_wb_queue_fwd.sv | 25 ++
 rtl/regfile_wb_queue.sv | 107 ++++++++++
 tb/tb_regfile_wb_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Register-file sizing shared by the register bank and its write-back queue.
package regfile_pkg;
    localparam int RF_DATA_W    = 32;
    localparam int RF_ADDR_W    = 5;
    localparam int RF_WBQ_DEPTH = 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/regfile_wb_queue_fwd.sv
// Youngest-match search over the pending write-back entries for one source port.
module wbq_fwd_lookup #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic [DEPTH-1:0]             vld_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0] dest_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0]            src_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            data_o
);
    // Entries arrive oldest-first, so the last match in the scan is the youngest.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_i[i] && (dest_i[i] == src_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[i];
            end
        end
    end
endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue in front of the register-file write port, with
// forwarding of pending writes to both source specifiers.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DEPTH  = RF_WBQ_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_dr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    output logic              write,
    output logic [ADDR_W-1:0] dr,
    output logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] Sr1,
    input  logic [ADDR_W-1:0] Sr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [ADDR_W-1:0] count
);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] dest_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         enq, deq, not_empty;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign write     = not_empty && !stall;
    assign dr        = not_empty ? dest_q[rd_ptr_q] : '0;
    assign wrData    = not_empty ? data_q[rd_ptr_q] : '0;
    assign count     = ADDR_W'(count_q);

    assign enq = in_valid && in_ready;
    assign deq = write;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; validity comes solely from count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            dest_q[wr_ptr_q] <= in_dr;
            data_q[wr_ptr_q] <= in_data;
        end
    end

    // Rotate the ring into age order (index 0 = head) for the lookups.
    logic [DEPTH-1:0]             age_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] age_dest;
    logic [DEPTH-1:0][DATA_W-1:0] age_data;

    always_comb begin
        age_vld  = '0;
        age_dest = '0;
        age_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_vld[i]  = (CNT_W'(i) < count_q);
            age_dest[i] = dest_q[rd_ptr_q + PTR_W'(i)];
            age_data[i] = data_q[rd_ptr_q + PTR_W'(i)];
        end
    end

    wbq_fwd_lookup #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd1 (
        .vld_i  (age_vld),
        .dest_i (age_dest),
        .data_i (age_data),
        .src_i  (Sr1),
        .hit_o  (fwd_hit1),
        .data_o (fwd_data1)
    );

    wbq_fwd_lookup #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd2 (
        .vld_i  (age_vld),
        .dest_i (age_dest),
        .data_i (age_data),
        .src_i  (Sr2),
        .hit_o  (fwd_hit2),
        .data_o (fwd_data2)
    );
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for the write-back queue: ordering, stall, full, forwarding, wrap, reset.
module tb_regfile_wb_queue;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_dr;
    logic [DATA_W-1:0] in_data;
    logic              stall;
    logic              write;
    logic [ADDR_W-1:0] dr;
    logic [DATA_W-1:0] wrData;
    logic [ADDR_W-1:0] Sr1, Sr2;
    logic              fwd_hit1, fwd_hit2;
    logic [DATA_W-1:0] fwd_data1, fwd_data2;
    logic [ADDR_W-1:0] count;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_dr(in_dr), .in_data(in_data),
        .stall(stall), .write(write), .dr(dr), .wrData(wrData),
        .Sr1(Sr1), .Sr2(Sr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
        in_valid = 1'b1;
        in_dr    = d;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    logic [ADDR_W+DATA_W-1:0] q[$];
    logic [ADDR_W+DATA_W-1:0] ent;
    int sent, written, sz;
    logic exp_wr;

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_dr = '0; in_data = '0;
        stall = 1'b0; Sr1 = '0; Sr2 = '0;
        #2;
        chk("rst_write", write, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_dr", dr, 0);
        chk("rst_wrData", wrData, 0);
        chk("rst_hit1", fwd_hit1, 0);
        chk("rst_fdata1", fwd_data1, 0);
        tick(); tick();
        #2 reset = 1'b1;
        tick();

        // single request, minimum latency
        in_valid = 1'b1; in_dr = 5'd3; in_data = 32'h33;
        #1 chk("t1_write_before", write, 0);
        tick();
        in_valid = 1'b0;
        chk("t1_write", write, 1);
        chk("t1_dr", dr, 3);
        chk("t1_wrData", wrData, 32'h33);
        chk("t1_count", count, 1);
        tick();
        chk("t1_count_after", count, 0);
        chk("t1_write_after", write, 0);
        chk("t1_dr_empty", dr, 0);

        // fill under stall
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) push(ADDR_W'(i), 32'hA0 + DATA_W'(i));
        chk("t2_count_full", count, 4);
        chk("t2_ready_full", in_ready, 0);
        chk("t2_write_stalled", write, 0);
        chk("t2_dr_head", dr, 1);

        // full and draining with in_valid high: no enqueue
        stall = 1'b0; in_valid = 1'b1; in_dr = 5'd9; in_data = 32'h99;
        #1 chk("t3_ready", in_ready, 0);
        chk("t3_write", write, 1);
        chk("t3_wrData", wrData, 32'hA1);
        tick();
        in_valid = 1'b0;
        chk("t3_count", count, 3);
        for (int i = 2; i <= 4; i++) begin
            chk("t2_order_write", write, 1);
            chk("t2_order_dr", dr, i);
            chk("t2_order_data", wrData, 32'hA0 + i);
            tick();
        end
        chk("t2_drained", count, 0);

        // forwarding
        stall = 1'b1; Sr1 = 5'd7; Sr2 = 5'd8;
        push(5'd7, 32'h10);
        push(5'd7, 32'h20);
        push(5'd5, 32'h55);
        chk("t4_hit1", fwd_hit1, 1);
        chk("t4_fdata1", fwd_data1, 32'h20);
        chk("t4_hit2", fwd_hit2, 0);
        chk("t4_fdata2", fwd_data2, 0);
        Sr2 = 5'd5;
        #1 chk("t4_fdata2_r5", fwd_data2, 32'h55);
        Sr2 = 5'd8; in_valid = 1'b1; in_dr = 5'd8; in_data = 32'h88;
        #1 chk("t4_inflight_hit2", fwd_hit2, 0);
        tick();
        in_valid = 1'b0;
        chk("t4_enq_hit2", fwd_hit2, 1);
        chk("t4_enq_fdata2", fwd_data2, 32'h88);
        stall = 1'b0;
        #1 chk("t4_head_youngest", fwd_data1, 32'h20);
        tick(); tick(); tick();
        chk("t4_head_write", write, 1);
        chk("t4_head_hit2", fwd_hit2, 1);
        chk("t4_head_fdata2", fwd_data2, 32'h88);
        chk("t4_head_hit1", fwd_hit1, 0);
        tick();
        chk("t4_drained", count, 0);

        // wrap with stall toggling, scoreboarded
        sent = 0; written = 0; q.delete();
        for (int cyc = 0; cyc < 80 && written < 10; cyc++) begin
            stall    = (cyc % 4 == 1) || (cyc % 4 == 2);
            in_valid = (sent < 10);
            in_dr    = ADDR_W'(10 + sent);
            in_data  = 32'h100 + DATA_W'(sent);
            #1;
            sz     = q.size();
            exp_wr = (sz != 0) && !stall;
            chk("t5_count", count, sz);
            chk("t5_ready", in_ready, sz != DEPTH);
            chk("t5_write", write, exp_wr);
            if (exp_wr) begin
                ent = q.pop_front();
                chk("t5_dr", dr, ent[ADDR_W+DATA_W-1:DATA_W]);
                chk("t5_wrData", wrData, ent[DATA_W-1:0]);
                written++;
            end
            if (in_valid && sz != DEPTH) begin
                q.push_back({in_dr, in_data});
                sent++;
            end
            tick();
        end
        in_valid = 1'b0; stall = 1'b0;
        chk("t5_written", written, 10);
        chk("t5_empty", count, 0);

        // reset mid-drain
        stall = 1'b1;
        push(5'd1, 32'h1); push(5'd2, 32'h2); push(5'd3, 32'h3);
        chk("t6_count3", count, 3);
        stall = 1'b0;
        tick();
        chk("t6_count2", count, 2);
        #2 reset = 1'b0;
        #1 chk("t6_write_now", write, 0);
        chk("t6_count_now", count, 0);
        chk("t6_ready_now", in_ready, 1);
        tick();
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_write", write, 0);
            chk("t6_count_zero", count, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
